// File: rtl/pc_fetch.sv
// Fetch stage: owns the architectural PC and fetches one instruction at a time from imem.
// The optional misaligned-next-PC trap is enabled by the FETCH_ALIGN_CHK_EN macro.
module pc_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned FETCH_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt_i,
    input  logic [31:0]            npc_i,
    output logic [31:0]            pc_o,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    output logic [31:0]            inst_o,
    input  logic                   inst_ready,
    output logic [FETCH_CNT_W-1:0] fetch_cnt,
    output logic                   fetch_err
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            inst_q, inst_d;
    logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   req_c;
`ifdef FETCH_ALIGN_CHK_EN
    logic                   err_q, err_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            cnt_q   <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
`ifdef FETCH_ALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and request logic; only one imem request is ever outstanding
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_REQ: begin
                req_c = ~halt_i & ~rst;
                if (req_c && imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ready) begin
                    cnt_d = cnt_q + FETCH_CNT_W'(1);
`ifdef FETCH_ALIGN_CHK_EN
                    pc_d  = npc_i;
                    if (npc_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                    end
`else
                    // Low bits are forced to word alignment when the trap is disabled
                    pc_d    = npc_i & 32'hFFFF_FFFC;
                    state_d = S_REQ;
`endif
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign pc_o       = pc_q;
    assign imem_req   = req_c;
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == S_VALID);
    assign inst_o     = inst_q;
    assign fetch_cnt  = cnt_q;
`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_err  = err_q;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected (inst, pc) pairs into a scoreboard
// that a separate monitor pops on every decode handshake.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i;
    logic [31:0] npc_i;
    logic [31:0] pc_o;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic        inst_ready;
    logic [31:0] fetch_cnt;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] exp_q[$];

    pc_fetch #(
        .RESET_PC   (32'h0000_3000),
        .FETCH_CNT_W(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .halt_i     (halt_i),
        .npc_i      (npc_i),
        .pc_o       (pc_o),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_o     (inst_o),
        .inst_ready (inst_ready),
        .fetch_cnt  (fetch_cnt),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every decode handshake must match the oldest expected entry
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected inst=%h pc=%h with empty scoreboard", inst_o, pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", inst_o, e[63:32]);
                chk("sb_pc", pc_o, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        chk("rst_pc", pc_o, 32'h0000_3000);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chkb("rst_valid", inst_valid, 1'b0);
        chkb("rst_err", fetch_err, 1'b0);
        chkb("rst_req", imem_req, 1'b0);
        rst = 1'b0;
    endtask

    // One full fetch: grant, optional halted WAIT cycles, rvalid, optional decode stall, handshake
    task automatic fetch_one(input logic [31:0] addr_exp, input logic [31:0] word,
                             input logic [31:0] npc, input int stall, input int wait_halt);
        int n;
        n = 0;
        #1;
        while (!imem_req && n < 50) begin
            step();
            #1;
            n++;
        end
        chkb("req_seen", imem_req, 1'b1);
        chk("imem_addr", imem_addr, addr_exp);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chkb("wait_no_valid", inst_valid, 1'b0);
        if (wait_halt > 0) begin
            halt_i = 1'b1;
            for (int k = 0; k < wait_halt; k++) begin
                step();
                #1;
                chkb("wait_no_req", imem_req, 1'b0);
            end
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        exp_q.push_back({word, addr_exp});
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        halt_i      = 1'b0;
        chkb("valid_up", inst_valid, 1'b1);
        for (int k = 0; k < stall; k++) begin
            npc_i = 32'hDEAD_0000 + 32'(k * 4);
            step();
            #1;
            chkb("stall_valid", inst_valid, 1'b1);
            chk("stall_inst", inst_o, word);
            chk("stall_pc", pc_o, addr_exp);
            chkb("stall_no_req", imem_req, 1'b0);
        end
        npc_i      = npc;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst         = 1'b1;
        halt_i      = 1'b0;
        npc_i       = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;

        // 1: first fetch after reset
        do_reset();
        fetch_one(32'h0000_3000, 32'h2408_0005, 32'h0000_3004, 0, 0);
        chk("t1_cnt", fetch_cnt, 32'd1);

        // 2: back-to-back sequential fetches, 3 cycles each
        do_reset();
        start = cyc;
        fetch_one(32'h0000_3000, 32'h1111_0000, 32'h0000_3004, 0, 0);
        fetch_one(32'h0000_3004, 32'h1111_0001, 32'h0000_3008, 0, 0);
        fetch_one(32'h0000_3008, 32'h1111_0002, 32'h0000_300C, 0, 0);
        fetch_one(32'h0000_300C, 32'h1111_0003, 32'h0000_3010, 0, 0);
        chk("t2_cycles", 32'(cyc - start), 32'd12);
        chk("t2_cnt", fetch_cnt, 32'd4);

        // 3: decode stall with npc_i churning; only the handshake value loads
        fetch_one(32'h0000_3010, 32'h8C09_0000, 32'h0000_3020, 5, 0);
        fetch_one(32'h0000_3020, 32'hAD0A_0004, 32'h0000_3024, 0, 0);
        chk("t3_cnt", fetch_cnt, 32'd6);

        // 4: halt in REQ, then halt during WAIT
        halt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chkb("t4_halt_req", imem_req, 1'b0);
            step();
        end
        chk("t4_halt_pc", pc_o, 32'h0000_3024);
        halt_i = 1'b0;
        #1;
        chkb("t4_release_req", imem_req, 1'b1);
        fetch_one(32'h0000_3024, 32'h0000_0020, 32'h0000_3028, 0, 0);
        fetch_one(32'h0000_3028, 32'h0000_0021, 32'h0000_302C, 0, 2);
        chk("t4_cnt", fetch_cnt, 32'd8);

        // 5: reset while a response is pending; the late rvalid must be dropped
        do_reset();
        #1;
        chk("t5_addr0", imem_addr, 32'h0000_3000);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        #1;
        chkb("t5_rst_req", imem_req, 1'b0);
        chk("t5_rst_pc", pc_o, 32'h0000_3000);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chkb("t5_late_valid", inst_valid, 1'b0);
        chkb("t5_req", imem_req, 1'b1);
        chk("t5_addr", imem_addr, 32'h0000_3000);
        step();
        #1;
        chkb("t5_still_invalid", inst_valid, 1'b0);
        fetch_one(32'h0000_3000, 32'h3C01_1234, 32'h0000_3004, 0, 0);
        chk("t5_cnt", fetch_cnt, 32'd1);

        // 6: misaligned next PC
        do_reset();
        fetch_one(32'h0000_3000, 32'h0000_0066, 32'h0000_3006, 0, 0);
        #1;
`ifdef FETCH_ALIGN_CHK_EN
        chkb("t6_err", fetch_err, 1'b1);
        chk("t6_pc", pc_o, 32'h0000_3006);
        for (int k = 0; k < 5; k++) begin
            chkb("t6_no_req", imem_req, 1'b0);
            chkb("t6_no_valid", inst_valid, 1'b0);
            step();
            #1;
        end
        do_reset();
        chkb("t6_err_cleared", fetch_err, 1'b0);
`else
        chkb("t6_err", fetch_err, 1'b0);
        chk("t6_pc", pc_o, 32'h0000_3004);
        fetch_one(32'h0000_3004, 32'h0000_0067, 32'h0000_3008, 0, 0);
        chk("t6_cnt", fetch_cnt, 32'd2);
`endif

        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
